// File: rtl/signal_gen_core.sv
// Waveform generator core: prescaled phase accumulator driving a sine ROM lookup
// or computed sawtooth/triangle/square outputs, all aligned to a 3-clock latency.
module signal_gen_core #(
  parameter int PHASE_W      = 24,
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 16,
  parameter int DIV          = 50,
  parameter int STEP_DEFAULT = 4096,
  parameter int STEP_INC     = 256,
  parameter logic [PHASE_W-1:0] STEP_MAX = {1'b1, {(PHASE_W-1){1'b0}}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              up,
  input  logic              down,
  input  logic [1:0]        mode,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] sample,
  output logic              sample_valid,
  output logic [PHASE_W-1:0] step
);

  typedef enum logic [1:0] {
    MODE_SINE = 2'd0,
    MODE_SAW  = 2'd1,
    MODE_TRI  = 2'd2,
    MODE_SQR  = 2'd3
  } mode_e;

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(DIV - 1);
  localparam logic [PHASE_W-1:0] C_DEFAULT  = PHASE_W'(STEP_DEFAULT);
  localparam logic [PHASE_W-1:0] C_INC      = PHASE_W'(STEP_INC);
  localparam logic [PHASE_W-1:0] C_UP_LIMIT = STEP_MAX - C_INC;
  localparam logic [PHASE_W-1:0] C_DN_LIMIT = C_INC << 1;
  localparam logic [DATA_W-1:0]  C_MIDSCALE = {1'b1, {(DATA_W-1){1'b0}}};

  logic [CNT_W-1:0]   r_count;
  logic [PHASE_W-1:0] r_step;
  logic [PHASE_W-1:0] r_phase;
  mode_e              r_modeLat;
  logic               r_tick1;
  logic               r_tick2;
  logic [DATA_W:0]    r_phaseDly;
  mode_e              r_modeDly;
  logic [DATA_W-1:0]  r_sample;
  logic               r_valid;

  logic               w_tick;
  logic [PHASE_W-1:0] w_stepNext;
  logic [DATA_W-1:0]  w_tri;
  logic [DATA_W-1:0]  w_wave;

  assign w_tick = en && (r_count == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= w_tick ? '0 : r_count + 1'b1;
    end
  end

  // Simultaneous up and down cancel; the step never reaches zero.
  always_comb begin
    w_stepNext = r_step;
    if (up && !down) begin
      w_stepNext = (r_step >= C_UP_LIMIT) ? STEP_MAX : r_step + C_INC;
    end else if (down && !up) begin
      w_stepNext = (r_step < C_DN_LIMIT) ? C_INC : r_step - C_INC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step <= C_DEFAULT;
    end else begin
      r_step <= w_stepNext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase   <= '0;
      r_modeLat <= MODE_SINE;
    end else if (w_tick) begin
      r_phase   <= r_phase + r_step;
      r_modeLat <= mode_e'(mode);
    end
  end

  assign rom_addr = r_phase[PHASE_W-1 -: ADDR_W];

  // Phase and mode are delayed one stage so computed waveforms line up with rom_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick1    <= 1'b0;
      r_tick2    <= 1'b0;
      r_phaseDly <= '0;
      r_modeDly  <= MODE_SINE;
      r_sample   <= C_MIDSCALE;
      r_valid    <= 1'b0;
    end else begin
      r_tick1    <= w_tick;
      r_tick2    <= r_tick1;
      r_phaseDly <= r_phase[PHASE_W-1 -: DATA_W+1];
      r_modeDly  <= r_modeLat;
      r_valid    <= r_tick2;
      if (r_tick2) begin
        r_sample <= w_wave;
      end
    end
  end

  always_comb begin
    w_tri  = r_phaseDly[DATA_W-1:0];
    w_wave = rom_data;
    case (r_modeDly)
      MODE_SINE: w_wave = rom_data;
      MODE_SAW:  w_wave = r_phaseDly[DATA_W:1];
      MODE_TRI:  w_wave = r_phaseDly[DATA_W] ? ~w_tri : w_tri;
      default:   w_wave = r_phaseDly[DATA_W] ? '0 : '1;
    endcase
  end

  assign sample       = r_sample;
  assign sample_valid = r_valid;
  assign step         = r_step;

endmodule

// File: tb/tb_signal_gen_core.sv
// Bench for signal_gen_core: queue-based reference model checked every clock,
// table-driven step vectors and hand-written reset/pipeline/saturation sequences.
module tb_signal_gen_core;

  localparam int PHASE_W = 24;
  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 16;
  localparam int DIV     = 4;
  localparam longint STEP_DEF = 4096;
  localparam longint STEP_INC = 256;
  localparam longint STEP_MAX = 64'h80_0000;

  logic clk = 1'b0;
  logic rst_n, en, up, down;
  logic [1:0] mode;
  logic [ADDR_W-1:0] romAddr, romAddr1;
  logic [DATA_W-1:0] romData, romData1, sample, sample1;
  logic sampleValid, sampleValid1;
  logic [PHASE_W-1:0] step, step1;
  logic [DATA_W-1:0] romMem [0:(1<<ADDR_W)-1];

  signal_gen_core #(.DIV(DIV)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .down(down), .mode(mode),
    .rom_addr(romAddr), .rom_data(romData), .sample(sample),
    .sample_valid(sampleValid), .step(step)
  );

  signal_gen_core #(.DIV(1)) u_div1 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .down(down), .mode(mode),
    .rom_addr(romAddr1), .rom_data(romData1), .sample(sample1),
    .sample_valid(sampleValid1), .step(step1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    romData  <= romMem[romAddr];
    romData1 <= romMem[romAddr1];
  end

  typedef struct {
    int                due;
    logic [DATA_W-1:0] value;
  } exp_t;

  typedef struct {
    logic               en;
    logic               up;
    logic               down;
    logic [1:0]         mode;
    logic [PHASE_W-1:0] expStep;
  } vec_t;

  exp_t expQ[$];
  int cycle = 0;
  int cnt = 0;
  logic [PHASE_W-1:0] mPhase;
  longint mStep;
  logic [DATA_W-1:0] mSample;
  int vectors = 0;
  int miscompares = 0;
  int validsSeen = 0;
  int firstValidCycle = 0;
  int releaseCycle = 0;
  logic [DATA_W-1:0] firstSample, lastSample;

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cycle, act, exp);
    end
  endtask

  // Waveform values from phase as a fraction of one period.
  function automatic logic [DATA_W-1:0] waveOf(input logic [PHASE_W-1:0] p, input logic [1:0] m);
    int pi;
    int pos;
    pi = int'(p);
    case (m)
      2'd0: return romMem[pi / (1 << (PHASE_W - ADDR_W))];
      2'd1: return DATA_W'(pi / 256);
      2'd2: begin
        pos = (pi % (1 << 23)) / 128;
        return (pi >= (1 << 23)) ? DATA_W'(65535 - pos) : DATA_W'(pos);
      end
      default: return (pi < (1 << 23)) ? 16'hFFFF : 16'h0000;
    endcase
  endfunction

  task automatic checkOutput();
    bit expValid;
    expValid = (expQ.size() > 0) && (expQ[0].due == cycle);
    if (expValid) begin
      mSample = expQ[0].value;
      expQ.delete(0);
    end
    if (sampleValid) begin
      validsSeen++;
      lastSample = sample;
      if (validsSeen == 1) begin
        firstSample = sample;
        firstValidCycle = cycle;
      end
    end
    checkEq("sample_valid", 32'(sampleValid), 32'(expValid));
    checkEq("sample", 32'(sample), 32'(mSample));
    checkEq("step", 32'(step), 32'(mStep));
    checkEq("rom_addr", 32'(romAddr), 32'(int'(mPhase) / (1 << (PHASE_W - ADDR_W))));
  endtask

  task automatic applyStimulus(input logic iEn, input logic iUp, input logic iDown,
                               input logic [1:0] iMode);
    exp_t e;
    en = iEn;
    up = iUp;
    down = iDown;
    mode = iMode;
    if (iEn && cnt == DIV - 1) begin
      mPhase = mPhase + PHASE_W'(mStep);
      e.due = cycle + 3;
      e.value = waveOf(mPhase, iMode);
      expQ.push_back(e);
    end
    if (iEn) cnt = (cnt + 1) % DIV;
    if (iUp && !iDown) begin
      mStep = (mStep + STEP_INC > STEP_MAX) ? STEP_MAX : mStep + STEP_INC;
    end else if (iDown && !iUp) begin
      mStep = (mStep - STEP_INC < STEP_INC) ? STEP_INC : mStep - STEP_INC;
    end
    cycle++;
  endtask

  task automatic runCycle(input logic iEn, input logic iUp, input logic iDown,
                          input logic [1:0] iMode);
    checkOutput();
    applyStimulus(iEn, iUp, iDown, iMode);
    @(negedge clk);
  endtask

  // Drops rst_n between edges, checks the immediate effect, releases at the next negedge.
  task automatic pulseReset(input logic iEn, input logic [1:0] iMode);
    #2 rst_n = 1'b0;
    #1;
    checkEq("rst_sample", 32'(sample), 32'h8000);
    checkEq("rst_valid", 32'(sampleValid), 32'h0);
    checkEq("rst_step", 32'(step), 32'(STEP_DEF));
    checkEq("rst_rom_addr", 32'(romAddr), 32'h0);
    expQ.delete();
    cnt = 0;
    mPhase = '0;
    mStep = STEP_DEF;
    mSample = 16'h8000;
    validsSeen = 0;
    @(negedge clk);
    cycle++;
    checkOutput();
    rst_n = 1'b1;
    releaseCycle = cycle;
    applyStimulus(iEn, 1'b0, 1'b0, iMode);
    @(negedge clk);
  endtask

  task automatic setStep(input longint target, input logic iEn, input logic [1:0] iMode);
    int guard;
    guard = 0;
    while (mStep != target && guard < 10000) begin
      if (mStep < target) runCycle(iEn, 1'b1, 1'b0, iMode);
      else runCycle(iEn, 1'b0, 1'b1, iMode);
      guard++;
    end
    checkEq("set_step", 32'(step), 32'(target));
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t tbl[9];
    logic [DATA_W-1:0] prev1, held;
    logic [ADDR_W-1:0] heldAddr;
    int k;

    tbl[0] = '{1'b1, 1'b0, 1'b1, 2'd1, 24'd3840};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 2'd1, 24'd3584};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 2'd1, 24'd3584};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 2'd1, 24'd3840};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 2'd1, 24'd4096};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 2'd1, 24'd4096};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 2'd1, 24'd4352};
    tbl[7] = '{1'b1, 1'b0, 1'b1, 2'd1, 24'd4096};
    tbl[8] = '{1'b1, 1'b1, 1'b1, 2'd1, 24'd4096};

    for (int i = 0; i < (1 << ADDR_W); i++) romMem[i] = DATA_W'($urandom);
    rst_n = 1'b1;
    en = 1'b0;
    up = 1'b0;
    down = 1'b0;
    mode = 2'd0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    $display("[TB] reset and sawtooth start-up");
    pulseReset(1'b1, 2'd1);

    for (int i = 0; i < 4; i++) runCycle(1'b1, 1'b0, 1'b0, 2'd1);
    prev1 = sample1;
    for (int i = 0; i < 30; i++) begin
      runCycle(1'b1, 1'b0, 1'b0, 2'd1);
      checkEq("div1_valid", 32'(sampleValid1), 32'h1);
      checkEq("div1_delta", 32'(DATA_W'(sample1 - prev1)), 32'h10);
      prev1 = sample1;
    end

    k = 0;
    while (validsSeen < 4096 && k < 17000) begin
      runCycle(1'b1, 1'b0, 1'b0, 2'd1);
      k++;
    end
    checkEq("saw_tick_count", 32'(validsSeen), 32'd4096);
    checkEq("saw_first", 32'(firstSample), 32'h10);
    checkEq("saw_latency", 32'(firstValidCycle - releaseCycle), 32'd6);
    checkEq("saw_wrap", 32'(lastSample), 32'h0);

    $display("[TB] step table");
    for (int i = 0; i < 9; i++) begin
      runCycle(tbl[i].en, tbl[i].up, tbl[i].down, tbl[i].mode);
      checkEq("table_step", 32'(step), 32'(tbl[i].expStep));
    end
    for (int i = 0; i < 20; i++) runCycle(1'b1, 1'b0, 1'b1, 2'd1);
    checkEq("step_floor", 32'(step), 32'd256);
    runCycle(1'b1, 1'b1, 1'b1, 2'd1);
    checkEq("step_updown", 32'(step), 32'd256);

    $display("[TB] enable hold");
    for (int i = 0; i < 10; i++) runCycle(1'b1, 1'b0, 1'b0, 2'd1);
    for (int i = 0; i < 100; i++) begin
      runCycle(1'b0, 1'b0, 1'b0, 2'd1);
      if (i == 10) begin
        held = sample;
        heldAddr = romAddr;
      end
    end
    checkEq("hold_sample", 32'(sample), 32'(held));
    checkEq("hold_addr", 32'(romAddr), 32'(heldAddr));
    for (int i = 0; i < 40; i++) runCycle(1'b1, 1'b0, 1'b0, 2'd1);

    $display("[TB] sine");
    pulseReset(1'b0, 2'd0);
    setStep(16384, 1'b0, 2'd0);
    for (int i = 0; i < 120; i++) runCycle(1'b1, 1'b0, 1'b0, 2'd0);
    checkEq("sine_addr", 32'(romAddr), 32'd30);

    $display("[TB] triangle and square");
    pulseReset(1'b0, 2'd2);
    setStep(64'h10_0000, 1'b0, 2'd2);
    for (int i = 0; i < 80; i++) runCycle(1'b1, 1'b0, 1'b0, 2'd2);
    for (int i = 0; i < 80; i++) runCycle(1'b1, 1'b0, 1'b0, 2'd3);

    $display("[TB] step ceiling");
    for (int i = 0; i < 29000; i++) runCycle(1'b1, 1'b1, 1'b0, 2'd1);
    checkEq("step_ceiling", 32'(step), 32'h80_0000);
    runCycle(1'b1, 1'b1, 1'b0, 2'd1);
    checkEq("step_ceiling_hold", 32'(step), 32'h80_0000);

    $display("[TB] random stimulus");
    for (int i = 0; i < 4000; i++) begin
      int r;
      if (i == 2000) pulseReset(1'b1, 2'($urandom_range(0, 3)));
      r = $urandom_range(0, 15);
      runCycle(($urandom_range(0, 9) != 0), (r == 0 || r == 1), (r == 1 || r == 2),
               2'($urandom_range(0, 3)));
    end
    for (int i = 0; i < 8; i++) runCycle(1'b0, 1'b0, 1'b0, 2'd0);
    checkEq("drain_empty", 32'(expQ.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
